// File: rtl/reg_pipe.sv
// reg_pipe: bubble-collapsing valid/ready register pipeline with synchronous flush
module reg_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
  localparam int OW = $clog2(DEPTH+1);
  logic [DEPTH-1:0] v, slot, ld, mv;
  logic [DEPTH:0] nxt, lv;
  logic [DEPTH-1:0][WIDTH-1:0] d;
  logic [DEPTH:0][WIDTH-1:0] src;
  genvar i;
  for (i = 0; i < DEPTH; i++) begin : g_slot
    assign slot[i] = out_ready | ~&v[DEPTH-1:i];
  end
  assign nxt = {out_ready, slot};
  assign mv = v & nxt[DEPTH:1];
  assign lv = {mv, in_valid & in_ready};
  assign ld = lv[DEPTH-1:0];
  assign src = {d, in_data};
  assign in_ready = slot[0] & ~flush & ~rst;
  assign out_valid = v[DEPTH-1] & ~flush;
  assign out_data = d[DEPTH-1];
  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) occupancy = occupancy + OW'(v[k]);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      d <= {DEPTH{RESET_VAL}};
    end else if (flush) begin
      v <= '0;
    end else begin
      v <= ld | (v & ~mv);
      for (int k = 0; k < DEPTH; k++) if (ld[k]) d[k] <= src[k];
    end
  end
endmodule

// File: tb/tb_reg_pipe.sv
// tb_reg_pipe: vector table, directed corner cases and randomized positional model for reg_pipe
module tb_reg_pipe;
  localparam int W = 8;
  localparam int D = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [W-1:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic flush = 1'b0;
  logic [1:0] occupancy;
  int pass_cnt = 0;
  int tot_cnt = 0;
  typedef struct {
    logic iv;
    logic [7:0] id;
    logic ordy;
    logic ir;
    logic ov;
    logic [7:0] od;
    int occ;
  } vec_t;
  vec_t tbl[25];
  logic [7:0] qd[$];
  int qp[$];
  int np[$];

  reg_pipe #(.WIDTH(W), .DEPTH(D), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .flush(flush),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  task automatic outs(input string tag, input logic ir, input logic ov, input logic [7:0] od, input int occ);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(ir));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".out_data"}, 32'(out_data), 32'(od));
    chk({tag, ".occupancy"}, 32'(occupancy), 32'(occ));
  endtask

  task automatic drive(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
    in_valid = iv;
    in_data = id;
    out_ready = ordy;
    flush = fl;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int r = 0; r < 14; r++) begin
      tbl[r].iv = (r < 10);
      tbl[r].id = (r < 10) ? 8'(17 * (r + 1)) : 8'h00;
      tbl[r].ordy = 1'b1;
      tbl[r].ir = 1'b1;
      tbl[r].ov = (r >= 3 && r <= 12);
      tbl[r].od = (r < 3) ? 8'h00 : (r <= 12) ? 8'(17 * (r - 2)) : 8'hAA;
      tbl[r].occ = (r <= 10) ? ((r < 3) ? r : 3) : 13 - r;
    end
    tbl[14] = '{1'b1, 8'hB1, 1'b0, 1'b1, 1'b0, 8'hAA, 0};
    tbl[15] = '{1'b1, 8'hB2, 1'b0, 1'b1, 1'b0, 8'hAA, 1};
    tbl[16] = '{1'b1, 8'hB3, 1'b0, 1'b1, 1'b0, 8'hAA, 2};
    tbl[17] = '{1'b1, 8'hB4, 1'b0, 1'b0, 1'b1, 8'hB1, 3};
    tbl[18] = '{1'b1, 8'hB4, 1'b0, 1'b0, 1'b1, 8'hB1, 3};
    tbl[19] = '{1'b1, 8'hB4, 1'b1, 1'b1, 1'b1, 8'hB1, 3};
    tbl[20] = '{1'b1, 8'hB5, 1'b0, 1'b0, 1'b1, 8'hB2, 3};
    tbl[21] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hB2, 3};
    tbl[22] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hB3, 2};
    tbl[23] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hB4, 1};
    tbl[24] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hB4, 0};

    #1;
    outs("rst_hold", 1'b0, 1'b0, 8'h00, 0);
    tick;
    tick;
    outs("rst_hold2", 1'b0, 1'b0, 8'h00, 0);
    rst = 1'b0;
    #1;
    chk("rst_release.in_ready", 32'(in_ready), 32'd1);

    for (int r = 0; r < 25; r++) begin
      drive(tbl[r].iv, tbl[r].id, tbl[r].ordy, 1'b0);
      #1;
      outs($sformatf("vec%0d", r), tbl[r].ir, tbl[r].ov, tbl[r].od, tbl[r].occ);
      tick;
    end

    drive(1'b1, 8'hC1, 1'b0, 1'b0);
    tick;
    drive(1'b1, 8'hC2, 1'b0, 1'b0);
    tick;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick;
    #1;
    outs("pre_async_rst", 1'b1, 1'b1, 8'hC1, 2);
    #1;
    rst = 1'b1;
    #1;
    outs("async_rst", 1'b0, 1'b0, 8'h00, 0);
    rst = 1'b0;
    #1;
    chk("async_rst_release.in_ready", 32'(in_ready), 32'd1);
    tick;

    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    #1;
    chk("bubble_a.in_ready", 32'(in_ready), 32'd1);
    tick;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick;
    drive(1'b1, 8'h5B, 1'b0, 1'b0);
    #1;
    chk("bubble_b.in_ready", 32'(in_ready), 32'd1);
    tick;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick;
    outs("bubble_closed", 1'b1, 1'b1, 8'hA5, 2);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    #1;
    outs("bubble_out_a", 1'b1, 1'b1, 8'hA5, 2);
    tick;
    outs("bubble_out_b", 1'b1, 1'b1, 8'h5B, 1);
    tick;
    outs("bubble_empty", 1'b1, 1'b0, 8'h5B, 0);

    drive(1'b1, 8'hD1, 1'b0, 1'b0);
    tick;
    drive(1'b1, 8'hD2, 1'b0, 1'b0);
    tick;
    drive(1'b1, 8'hD3, 1'b0, 1'b0);
    tick;
    chk("flush_fill.occupancy", 32'(occupancy), 32'd3);
    drive(1'b1, 8'hE1, 1'b1, 1'b1);
    #1;
    chk("flush_cycle.in_ready", 32'(in_ready), 32'd0);
    chk("flush_cycle.out_valid", 32'(out_valid), 32'd0);
    tick;
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    #1;
    outs("post_flush", 1'b1, 1'b0, 8'hD1, 0);
    drive(1'b1, 8'hF1, 1'b1, 1'b0);
    tick;
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick;
    tick;
    outs("post_flush_word", 1'b1, 1'b1, 8'hF1, 1);
    tick;
    chk("post_flush_drain.occupancy", 32'(occupancy), 32'd0);

    for (int c = 0; c < 1000; c++) begin
      logic iv, ordy, eov, dep, eir;
      logic [7:0] id;
      int prev;
      iv = 1'($urandom_range(0, 1));
      ordy = ($urandom_range(0, 2) != 0);
      id = 8'($urandom);
      drive(iv, id, ordy, 1'b0);
      #1;
      eov = (qd.size() > 0) && (qp[0] == D - 1);
      dep = eov && ordy;
      np = {};
      prev = D;
      for (int k = 0; k < qp.size(); k++) begin
        if (k == 0 && dep) np.push_back(D);
        else np.push_back((qp[k] + 1 < prev - 1) ? qp[k] + 1 : prev - 1);
        prev = np[k];
      end
      eir = (qd.size() == 0) || (np[np.size() - 1] >= 1);
      chk("rnd.in_ready", 32'(in_ready), 32'(eir));
      chk("rnd.out_valid", 32'(out_valid), 32'(eov));
      chk("rnd.occupancy", 32'(occupancy), 32'((qd.size() < D) ? qd.size() : D));
      if (eov) chk("rnd.out_data", 32'(out_data), 32'(qd[0]));
      tick;
      if (dep) begin
        void'(qd.pop_front());
        void'(np.pop_front());
      end
      qp = np;
      if (iv && eir) begin
        qd.push_back(id);
        qp.push_back(0);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
